clock_tick_gen: RTL and testbench

CLOCK_TICK_GEN -- requirements
Module: clock_tick_gen

---
 rtl/clock_tick_gen_if.sv | 16 +
 rtl/clock_tick_gen.sv | 98 +++++++++
 tb/tb_clock_tick_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_tick_gen_if.sv
// Divisor configuration bus for clock_tick_gen: a valid/ready write of one
// channel's divisor.
interface clock_tick_gen_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 27
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_tick_gen.sv
// Multi-channel programmable tick generator: each channel divides clk by
// (div_act+1), emitting a one-cycle tick and a 50% square wave.
module clock_tick_gen #(
  parameter int          N_CH    = 2,
  parameter int          DIV_W   = 27,
  parameter logic [31:0] DEF_DIV = 32'd49_999_999
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  clock_tick_gen_if.slave cfg,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] sq,
  output logic [N_CH-1:0] pending
);
  localparam int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_VAL = DEF_DIV[DIV_W-1:0];

  logic [1:0] rst_pipe;
  logic       rst_int_n;
  logic       cfg_accept;

  // Reset asserts immediately but releases only after two clean clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n     = rst_pipe[1];
  assign cfg.cfg_ready = rst_int_n & ~sync;
  assign cfg_accept    = cfg.cfg_valid & cfg.cfg_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic             tick_r;
    logic             sq_r;
    logic             pend_r;
    logic             at_end;
    logic             wr;
    logic             apply;

    // >= rather than == so a divisor shrunk below cnt still wraps next cycle.
    assign at_end = (cnt >= div_act);
    assign wr     = cfg_accept && (cfg.cfg_ch == CH_IDX);
    assign apply  = pend_r && (sync || !en[i] || at_end);

    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        cnt     <= '0;
        div_act <= DEF_VAL;
        div_shd <= DEF_VAL;
        tick_r  <= 1'b0;
        sq_r    <= 1'b0;
        pend_r  <= 1'b0;
      end else begin
        if (sync) begin
          cnt    <= '0;
          tick_r <= 1'b0;
          sq_r   <= 1'b0;
        end else if (en[i]) begin
          if (at_end) begin
            cnt    <= '0;
            tick_r <= 1'b1;
            sq_r   <= ~sq_r;
          end else begin
            cnt    <= cnt + DIV_W'(1);
            tick_r <= 1'b0;
          end
        end else begin
          tick_r <= 1'b0;
        end

        // The shadow applied is the one held before any write this cycle.
        if (apply) begin
          div_act <= div_shd;
        end
        if (wr) begin
          div_shd <= cfg.cfg_div;
          pend_r  <= 1'b1;
        end else if (apply) begin
          pend_r  <= 1'b0;
        end
      end
    end

    assign tick[i]    = tick_r;
    assign sq[i]      = sq_r;
    assign pending[i] = pend_r;
  end
endmodule

// File: tb/tb_clock_tick_gen.sv
// Directed, self-checking bench for clock_tick_gen with N_CH=2, DIV_W=8,
// DEF_DIV=4: a vector table for steady counting plus hand-written corner cases.
module tb_clock_tick_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] en;
  logic       sync;
  logic [1:0] tick;
  logic [1:0] sq;
  logic [1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] en;
    logic       sync;
    logic       valid;
    logic       ch;
    logic [7:0] div;
    logic [1:0] exp_tick;
    logic [1:0] exp_sq;
    logic [1:0] exp_pend;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  clock_tick_gen_if #(.N_CH(2), .DIV_W(8)) cfg_if ();

  clock_tick_gen #(.N_CH(2), .DIV_W(8), .DEF_DIV(32'd4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .cfg     (cfg_if),
    .tick    (tick),
    .sq      (sq),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] e, input logic s, input logic v,
                               input logic c, input logic [7:0] d);
    en               = e;
    sync             = s;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = c;
    cfg_if.cfg_div   = d;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [1:0] got, input logic [1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s %s: got %b, expected %b", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] et, input logic [1:0] es,
                             input logic [1:0] ep, input logic er);
    checkField(name, "tick", tick, et);
    checkField(name, "sq", sq, es);
    checkField(name, "pending", pending, ep);
    checkField(name, "cfg_ready", {1'b0, cfg_if.cfg_ready}, {1'b0, er});
  endtask

  task automatic cyc(input string name, input logic [1:0] e, input logic s, input logic v,
                     input logic c, input logic [7:0] d, input logic [1:0] et,
                     input logic [1:0] es, input logic [1:0] ep, input logic er);
    applyStimulus(e, s, v, c, d);
    @(posedge clk);
    #1;
    checkOutput(name, et, es, ep, er);
  endtask

  initial begin
    logic s0;
    logic s1;
    logic t0;
    logic t1;
    s0 = 1'b0;
    s1 = 1'b0;
    // Edges counted from the first edge after the internal reset releases.
    // ch1 keeps divisor 4; ch0 gets divisor 9 written at cnt=2 before edge 23.
    for (int k = 1; k <= 45; k++) begin
      vec_t v;
      t0 = (k <= 25) ? (k % 5 == 0) : (k == 35 || k == 45);
      t1 = (k % 5 == 0);
      if (t0) s0 = ~s0;
      if (t1) s1 = ~s1;
      v.en        = 2'b11;
      v.sync      = 1'b0;
      v.valid     = (k == 23);
      v.ch        = 1'b0;
      v.div       = 8'd9;
      v.exp_tick  = {t1, t0};
      v.exp_sq    = {s1, s0};
      v.exp_pend  = {1'b0, (k == 23 || k == 24)};
      v.exp_ready = 1'b1;
      vecs.push_back(v);
    end

    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 2'b00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 2'b00, 2'b00, 2'b00, 1'b1);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].en, vecs[k].sync, vecs[k].valid, vecs[k].ch, vecs[k].div);
      @(posedge clk);
      #1;
      checkOutput($sformatf("tbl_edge%0d", k + 1), vecs[k].exp_tick, vecs[k].exp_sq,
                  vecs[k].exp_pend, vecs[k].exp_ready);
    end

    // ch1 frozen for 7 cycles at cnt=2, then finishes its period.
    cyc("frz_run1", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, 1);
    cyc("frz_run2", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, 1);
    for (int k = 0; k < 7; k++)
      cyc($sformatf("frz_hold%0d", k), 2'b01, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, 1);
    cyc("frz_ch0_wrap", 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b10, 2'b00, 1);
    cyc("frz_resume",   2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b10, 2'b00, 1);
    cyc("frz_ch1_wrap", 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00, 1);

    // sync lands on ch0's wrap cycle; a write offered with it must be refused.
    for (int k = 0; k < 4; k++)
      cyc("pre_sync", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("pre_sync_ch1", 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00, 1);
    cyc("pre_sync_a",   2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b10, 2'b00, 1);
    cyc("pre_sync_b",   2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b10, 2'b00, 1);
    cyc("sync_on_wrap", 2'b11, 1, 1, 1, 8'd7, 2'b00, 2'b00, 2'b00, 0);
    for (int k = 0; k < 4; k++)
      cyc("post_sync", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("post_sync_ch1", 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00, 1);
    for (int k = 0; k < 4; k++)
      cyc("post_sync_mid", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b10, 2'b00, 1);
    cyc("post_sync_both", 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b01, 2'b00, 1);

    // sync applies a pending ch1 divisor of 2 immediately.
    cyc("sync_apply_wr", 2'b11, 0, 1, 1, 8'd2, 2'b00, 2'b01, 2'b10, 1);
    cyc("sync_apply",    2'b11, 1, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 0);
    cyc("div2_a",  2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("div2_b",  2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("div2_t1", 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00, 1);
    cyc("div2_c",  2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b10, 2'b00, 1);
    cyc("div2_d",  2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b10, 2'b00, 1);
    cyc("div2_t2", 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00, 1);

    // Two writes to pending ch0: only the last (divisor 1) takes effect.
    cyc("ovr_wr3",   2'b11, 0, 1, 0, 8'd3, 2'b00, 2'b00, 2'b01, 1);
    cyc("ovr_wr1",   2'b11, 0, 1, 0, 8'd1, 2'b00, 2'b00, 2'b01, 1);
    cyc("ovr_wait",  2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b01, 1);
    cyc("ovr_wrap",  2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b11, 2'b00, 1);
    cyc("ovr_p1",    2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, 1);
    cyc("ovr_tick2", 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b00, 1);
    cyc("ovr_p2",    2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("ovr_tick3", 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, 1);

    // Write to disabled ch1 applies the next cycle without a wrap.
    cyc("dis_wr",    2'b01, 0, 1, 1, 8'd5, 2'b00, 2'b01, 2'b10, 1);
    cyc("dis_apply", 2'b01, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00, 1);
    cyc("dis_run3",  2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("dis_run4",  2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, 1);
    cyc("dis_run5",  2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b01, 2'b00, 1);
    cyc("dis_wrap",  2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b10, 2'b00, 1);

    // Divisor 0 on ch0: tick held high and sq toggling every cycle.
    cyc("z_sync",  2'b11, 1, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 0);
    cyc("z_wr",    2'b11, 0, 1, 0, 8'd0, 2'b00, 2'b00, 2'b01, 1);
    cyc("z_wrap",  2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, 1);
    cyc("z_c3",    2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00, 1);
    cyc("z_c4",    2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, 1);
    cyc("z_c5",    2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00, 1);
    cyc("z_c6",    2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b11, 2'b00, 1);
    cyc("z_c7",    2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b10, 2'b00, 1);

    // Reset while ch1 holds a pending divisor of 9: it must be discarded.
    cyc("rp_wr", 2'b11, 0, 1, 1, 8'd9, 2'b01, 2'b11, 2'b10, 1);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rp_assert", 2'b00, 2'b00, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rp_hold%0d", k), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rp_release", 2'b00, 2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 4; k++)
      cyc("rp_cnt", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, 1);
    cyc("rp_tick1", 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b11, 2'b00, 1);
    for (int k = 0; k < 4; k++)
      cyc("rp_cnt2", 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, 1);
    cyc("rp_tick2", 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
